// File: rtl/vga_sprite_engine_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sprite_engine_if
//  Description : Sprite bus between the physics core and the VGA sprite
//                compositor. The master supplies the shared sprite mask,
//                per-sprite positions and colours, the background colour, and
//                the update request. The slave returns the one-cycle update
//                acknowledge.
//  Signals     : sprite      [SIZE][SIZE] shared 1-bit mask, [row][col]
//                sprite_row  per-sprite centre row (visible coordinates)
//                sprite_col  per-sprite centre column
//                sprite_rgb  per-sprite colour {R,G,B}
//                bg_rgb      background colour
//                update_req  new positions/colours are present
//                update_ack  pulse: inputs captured into shadow registers
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_sprite_engine_if #(
   parameter int SPRITES = 4,
   parameter int SIZE    = 63
);
   logic [SIZE-1:0][SIZE-1:0]  sprite;
   logic [SPRITES-1:0][11:0]   sprite_row;
   logic [SPRITES-1:0][11:0]   sprite_col;
   logic [SPRITES-1:0][11:0]   sprite_rgb;
   logic [11:0]                bg_rgb;
   logic                       update_req;
   logic                       update_ack;

   modport master (
      output sprite, sprite_row, sprite_col, sprite_rgb, bg_rgb, update_req,
      input  update_ack
   );

   modport slave (
      input  sprite, sprite_row, sprite_col, sprite_rgb, bg_rgb, update_req,
      output update_ack
   );
endinterface
`default_nettype wire

// File: rtl/vga_sprite_engine.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sprite_engine
//  Description : Parametrised VGA timing generator with a multi-sprite
//                compositor. Sprite positions/colours are double-buffered in
//                shadow registers that only change at the frame boundary.
//  Ports       : clock_162          pixel clock
//                rst_l              asynchronous active-low reset
//                bus (slave)        sprite mask, positions, colours, bg,
//                                   update_req / update_ack handshake
//                RED, GREEN, BLUE   4-bit colour, 0 outside visible area
//                HSYNC, VSYNC       sync outputs (pulse level HS_POL/VS_POL)
//                frame_start        pulse aligned with col=0,row=0 at outputs
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sprite_engine #(
   parameter int   H_VISIBLE = 1600,
   parameter int   H_FRONT   = 64,
   parameter int   H_SYNC    = 192,
   parameter int   H_BACK    = 304,
   parameter int   V_VISIBLE = 1200,
   parameter int   V_FRONT   = 1,
   parameter int   V_SYNC    = 3,
   parameter int   V_BACK    = 46,
   parameter logic HS_POL    = 1'b0,
   parameter logic VS_POL    = 1'b0,
   parameter int   SPRITES   = 4,
   parameter int   SIZE      = 63
) (
   input  wire logic          clock_162,
   input  wire logic          rst_l,
   vga_sprite_engine_if.slave bus,
   output logic [3:0]         RED,
   output logic [3:0]         GREEN,
   output logic [3:0]         BLUE,
   output logic               HSYNC,
   output logic               VSYNC,
   output logic               frame_start
);

   localparam int c_H_OFF   = H_FRONT + H_SYNC + H_BACK;
   localparam int c_V_OFF   = V_FRONT + V_SYNC + V_BACK;
   localparam int c_H_TOTAL = c_H_OFF + H_VISIBLE;
   localparam int c_V_TOTAL = c_V_OFF + V_VISIBLE;
   localparam int c_HALF    = (SIZE - 1) / 2;
   localparam int c_IW      = $clog2(SIZE);

   localparam logic signed [12:0] c_HALF_S = 13'(c_HALF);

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_PENDING = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Raster counters
   // ------------------------------------------------------------------
   logic [11:0] r_col;
   logic [11:0] r_row;
   logic        w_line_end;
   logic        w_boundary;

   assign w_line_end = (r_col == 12'(c_H_TOTAL - 1));
   assign w_boundary = (r_col == 12'd0) && (r_row == 12'd0);

   always_ff @(posedge clock_162 or negedge rst_l) begin
      if (!rst_l) begin
         r_col <= '0;
         r_row <= '0;
      end else begin
         if (w_line_end) begin
            r_col <= '0;
            if (r_row == 12'(c_V_TOTAL - 1))
               r_row <= '0;
            else
               r_row <= r_row + 12'd1;
         end else begin
            r_col <= r_col + 12'd1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Update handshake FSM and shadow registers
   // ------------------------------------------------------------------
   state_t r_state;
   state_t w_state_nxt;
   logic   w_capture;

   always_ff @(posedge clock_162 or negedge rst_l) begin
      if (!rst_l)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // A request already present on the boundary cycle is taken immediately,
   // so a request made just in time still lands in the upcoming frame.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.update_req) begin
               if (w_boundary)
                  w_capture = 1'b1;
               else
                  w_state_nxt = ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (w_boundary) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.update_ack = w_capture;

   logic [SPRITES-1:0][11:0] r_sh_row;
   logic [SPRITES-1:0][11:0] r_sh_col;
   logic [SPRITES-1:0][11:0] r_sh_rgb;

   always_ff @(posedge clock_162 or negedge rst_l) begin
      if (!rst_l) begin
         r_sh_row <= '0;
         r_sh_col <= '0;
         r_sh_rgb <= '0;
      end else if (w_capture) begin
         r_sh_row <= bus.sprite_row;
         r_sh_col <= bus.sprite_col;
         r_sh_rgb <= bus.sprite_rgb;
      end
   end

   // ------------------------------------------------------------------
   // Stage 1: visible coordinates, visibility, sync levels, frame flag
   // ------------------------------------------------------------------
   logic signed [12:0] r_s1_x;
   logic signed [12:0] r_s1_y;
   logic               r_s1_vis;
   logic               r_s1_hs;
   logic               r_s1_vs;
   logic               r_s1_frame;
   logic               w_hs_act;
   logic               w_vs_act;
   logic               w_vis;

   assign w_hs_act = (r_col >= 12'(H_FRONT)) && (r_col < 12'(H_FRONT + H_SYNC));
   assign w_vs_act = (r_row >= 12'(V_FRONT)) && (r_row < 12'(V_FRONT + V_SYNC));
   assign w_vis    = (r_col >= 12'(c_H_OFF)) && (r_row >= 12'(c_V_OFF));

   always_ff @(posedge clock_162 or negedge rst_l) begin
      if (!rst_l) begin
         r_s1_x     <= '0;
         r_s1_y     <= '0;
         r_s1_vis   <= 1'b0;
         r_s1_hs    <= ~HS_POL;
         r_s1_vs    <= ~VS_POL;
         r_s1_frame <= 1'b0;
      end else begin
         r_s1_x     <= $signed({1'b0, r_col}) - 13'(c_H_OFF);
         r_s1_y     <= $signed({1'b0, r_row}) - 13'(c_V_OFF);
         r_s1_vis   <= w_vis;
         r_s1_hs    <= w_hs_act ? HS_POL : ~HS_POL;
         r_s1_vs    <= w_vs_act ? VS_POL : ~VS_POL;
         r_s1_frame <= w_boundary;
      end
   end

   // ------------------------------------------------------------------
   // Sprite hit tests. Differences are 13-bit signed, so a sprite hanging
   // off an edge is simply clipped instead of wrapping around.
   // ------------------------------------------------------------------
   logic [SPRITES-1:0] w_hit;

   for (genvar i = 0; i < SPRITES; i++) begin : g_sprite
      logic signed [12:0] w_dx;
      logic signed [12:0] w_dy;
      logic [c_IW-1:0]    w_ci;
      logic [c_IW-1:0]    w_ri;
      logic               w_in;

      assign w_dx = r_s1_x - $signed({1'b0, r_sh_col[i]});
      assign w_dy = r_s1_y - $signed({1'b0, r_sh_row[i]});
      assign w_in = (w_dx >= -c_HALF_S) && (w_dx <= c_HALF_S) &&
                    (w_dy >= -c_HALF_S) && (w_dy <= c_HALF_S);
      assign w_ci = c_IW'(w_dx + c_HALF_S);
      assign w_ri = c_IW'(w_dy + c_HALF_S);
      assign w_hit[i] = w_in && bus.sprite[w_ri][w_ci];
   end

   // Lowest index wins: walk from the highest index down so lower ones
   // overwrite.
   logic [11:0] w_pix;

   always_comb begin
      w_pix = bus.bg_rgb;
      for (int i = SPRITES - 1; i >= 0; i--) begin
         if (w_hit[i])
            w_pix = r_sh_rgb[i];
      end
   end

   // ------------------------------------------------------------------
   // Stage 2: output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock_162 or negedge rst_l) begin
      if (!rst_l) begin
         RED         <= '0;
         GREEN       <= '0;
         BLUE        <= '0;
         HSYNC       <= ~HS_POL;
         VSYNC       <= ~VS_POL;
         frame_start <= 1'b0;
      end else begin
         RED         <= r_s1_vis ? w_pix[11:8] : 4'd0;
         GREEN       <= r_s1_vis ? w_pix[7:4]  : 4'd0;
         BLUE        <= r_s1_vis ? w_pix[3:0]  : 4'd0;
         HSYNC       <= r_s1_hs;
         VSYNC       <= r_s1_vs;
         frame_start <= r_s1_frame;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_sprite_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sprite_engine
//  Description : Directed self-checking bench for vga_sprite_engine using a
//                reduced video mode: H 2/3/3/16 (total 24), V 1/2/2/12
//                (total 17), frame = 408 clocks, SIZE=5 (HALF=2), 2 sprites.
//                Visible pixel (x,y) is counter (x+8, y+5).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sprite_engine;

   localparam int c_HT    = 24;
   localparam int c_FRAME = 408;

   logic       clk;
   logic       rst_l;
   logic [3:0] red, green, blue;
   logic       hsync, vsync, frame_start;
   logic [11:0] rgb;

   int n_checks;
   int n_errors;
   int n;

   vga_sprite_engine_if #(.SPRITES(2), .SIZE(5)) bus ();

   vga_sprite_engine #(
      .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(12), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
      .HS_POL(1'b0), .VS_POL(1'b0), .SPRITES(2), .SIZE(5)
   ) dut (
      .clock_162   (clk),
      .rst_l       (rst_l),
      .bus         (bus),
      .RED         (red),
      .GREEN       (green),
      .BLUE        (blue),
      .HSYNC       (hsync),
      .VSYNC       (vsync),
      .frame_start (frame_start)
   );

   assign rgb = {red, green, blue};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts active edges since reset release; the counter sits at n mod 408
   // and the outputs show counter position n-2.
   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) n <= 0;
      else        n <= n + 1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance to the negedge where the outputs show counter (c, r).
   task automatic goto(input int c, input int r);
      int  target;
      bit  found;
      target = r * c_HT + c;
      found  = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
         @(negedge clk);
         if (n >= 2 && ((n - 2) % c_FRAME) == target) found = 1'b1;
      end
      check_eq($sformatf("reach_%0d_%0d", c, r), 32'(found), 32'd1);
   endtask

   // Visible pixel check.
   task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
      goto(x + 8, y + 5);
      check_eq(tag, 32'(rgb), 32'(exp));
   endtask

   task automatic do_update();
      bit seen;
      int acks;
      seen = 1'b0;
      bus.update_req = 1'b1;
      for (int k = 0; k < 1000 && !seen; k++) begin
         @(negedge clk);
         if (bus.update_ack) seen = 1'b1;
      end
      check_eq("ack_seen", 32'(seen), 32'd1);
      check_eq("ack_at_boundary", 32'(n % c_FRAME), 32'd0);
      @(posedge clk);
      #1 bus.update_req = 1'b0;
      acks = 0;
      for (int k = 0; k < 450; k++) begin
         @(negedge clk);
         if (bus.update_ack) acks++;
      end
      check_eq("ack_once", 32'(acks), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first_low;
      int low_cnt;
      int vis_cnt;
      int first_vis;

      n_checks = 0;
      n_errors = 0;
      rst_l    = 1'b0;
      bus.sprite         = '0;
      bus.sprite_row[0]  = 12'd6;
      bus.sprite_col[0]  = 12'd8;
      bus.sprite_rgb[0]  = 12'hF00;
      bus.sprite_row[1]  = 12'd6;
      bus.sprite_col[1]  = 12'd10;
      bus.sprite_rgb[1]  = 12'h0F0;
      bus.bg_rgb         = 12'h00F;
      bus.update_req     = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("rst_rgb",   32'(rgb), 32'h000);
      check_eq("rst_hsync", 32'(hsync), 32'd1);
      check_eq("rst_vsync", 32'(vsync), 32'd1);
      check_eq("rst_frame", 32'(frame_start), 32'd0);
      check_eq("rst_ack",   32'(bus.update_ack), 32'd0);
      rst_l = 1'b1;

      // First frame_start two edges after release.
      goto(0, 0);
      check_eq("first_frame_n", 32'(n), 32'd2);
      check_eq("frame_pulse", 32'(frame_start), 32'd1);
      check_eq("vsync_row0", 32'(vsync), 32'd1);

      // One line of HSYNC.
      first_low = -1;
      low_cnt   = 0;
      for (int i = 0; i < c_HT; i++) begin
         if (i > 0) @(negedge clk);
         if (hsync == 1'b0) begin
            low_cnt++;
            if (first_low < 0) first_low = i;
         end
      end
      check_eq("hsync_start", 32'(first_low), 32'd2);
      check_eq("hsync_width", 32'(low_cnt), 32'd3);

      goto(0, 1);
      check_eq("vsync_row1", 32'(vsync), 32'd0);
      check_eq("frame_gone", 32'(frame_start), 32'd0);
      goto(23, 2);
      check_eq("vsync_row2", 32'(vsync), 32'd0);
      goto(0, 3);
      check_eq("vsync_row3", 32'(vsync), 32'd1);

      // First visible line: background everywhere visible, 0 in blanking.
      goto(0, 5);
      vis_cnt   = 0;
      first_vis = -1;
      for (int i = 0; i < c_HT; i++) begin
         if (i > 0) @(negedge clk);
         if (rgb != 12'h000) begin
            vis_cnt++;
            if (first_vis < 0) first_vis = i;
         end
      end
      check_eq("visible_count", 32'(vis_cnt), 32'd16);
      check_eq("visible_start", 32'(first_vis), 32'd8);

      goto(0, 0);
      check_eq("frame_period", 32'(n), 32'd410);

      // Shadows are still zero: both sprites at (0,0) with colour 000.
      bus.sprite = '1;
      pix("zero_shadow_hit", 0, 0, 12'h000);
      pix("zero_shadow_bg",  3, 0, 12'h00F);

      // Update raised mid-frame: this frame keeps the old position.
      pix("old_frame", 6, 6, 12'h00F);
      do_update();
      pix("s0_above",     8, 3, 12'h00F);
      pix("s0_top_edge",  8, 4, 12'hF00);
      pix("s0_left_out",  5, 6, 12'h00F);
      pix("s0_left_edge", 6, 6, 12'hF00);
      pix("overlap_s0",  10, 6, 12'hF00);
      pix("s1_only",     12, 6, 12'h0F0);
      pix("s1_right_out",13, 6, 12'h00F);

      // Clipping at screen edges, no wrap.
      bus.sprite_row[0] = 12'd0;
      bus.sprite_col[0] = 12'd0;
      bus.sprite_row[1] = 12'd11;
      bus.sprite_col[1] = 12'd15;
      do_update();
      pix("corner_00",    0, 0, 12'hF00);
      pix("corner_20",    2, 0, 12'hF00);
      pix("corner_30",    3, 0, 12'h00F);
      pix("nowrap_14",   14, 0, 12'h00F);
      pix("nowrap_15",   15, 0, 12'h00F);
      pix("br_out",      12, 11, 12'h00F);
      pix("br_hit",      15, 11, 12'h0F0);

      // Asynchronous reset in mid-frame.
      pix("pre_reset", 2, 3, 12'h00F);
      #2 rst_l = 1'b0;
      #1;
      check_eq("async_rgb",   32'(rgb), 32'h000);
      check_eq("async_hsync", 32'(hsync), 32'd1);
      check_eq("async_frame", 32'(frame_start), 32'd0);
      repeat (2) @(negedge clk);
      rst_l = 1'b1;
      goto(0, 0);
      check_eq("restart_n", 32'(n), 32'd2);
      check_eq("restart_frame", 32'(frame_start), 32'd1);
      pix("shadow_cleared", 0, 0, 12'h000);
      goto(0, 0);
      check_eq("restart_period", 32'(n), 32'd410);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
